// File: rtl/io_port_pkg.sv
// Shared constants and types for the processor I/O port controller.
package io_port_pkg;
    localparam int DATA_W         = 16;
    localparam int OUT_DEPTH_DFLT = 4;

    typedef enum logic {
        RX_EMPTY  = 1'b0,
        RX_LOADED = 1'b1
    } rx_state_t;
endpackage

// File: rtl/io_out_fifo.sv
// Outbound synchronous FIFO: head word is combinational from storage,
// a push while full is taken only when a pop frees a slot in the same cycle.
module io_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             drop
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign rdata   = mem_q[rd_ptr_q];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage is cleared too so the head word reads 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/io_port_ctrl.sv
// Peripheral-side controller for the processor's 16-bit I/O ports.
// Define IO_RX_INT_EN to build the one-cycle receive interrupt; otherwise cpu_int is tied low.
module io_port_ctrl #(
    parameter int OUT_DEPTH = io_port_pkg::OUT_DEPTH_DFLT,
    parameter int DATA_W    = io_port_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] cpu_out_data,
    input  logic              cpu_out_we,
    output logic [DATA_W-1:0] cpu_in_data,
    input  logic              cpu_in_rd,
    output logic              cpu_int,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              out_ovf,
    output logic              in_unf
);
    import io_port_pkg::*;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_drop;
    rx_state_t         state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              rx_ready_q, rx_ready_d;
    logic              out_ovf_q, out_ovf_d;
    logic              in_unf_q, in_unf_d;
    logic              capture;

    io_out_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (DATA_W)
    ) u_out_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (cpu_out_we),
        .wdata (cpu_out_data),
        .pop   (tx_valid & tx_ready),
        .rdata (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    assign tx_valid = ~fifo_empty;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        in_unf_d  = in_unf_q;
        out_ovf_d = out_ovf_q | fifo_drop;
        capture   = 1'b0;
        case (state_q)
            RX_EMPTY: begin
                if (cpu_in_rd) begin
                    in_unf_d = 1'b1;
                end
                if (rx_valid) begin
                    capture = 1'b1;
                    hold_d  = rx_data;
                    state_d = RX_LOADED;
                end
            end
            RX_LOADED: begin
                if (cpu_in_rd) begin
                    state_d = RX_EMPTY;
                end
            end
            default: state_d = RX_EMPTY;
        endcase
        rx_ready_d = (state_d == RX_EMPTY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RX_EMPTY;
            hold_q     <= '0;
            rx_ready_q <= 1'b1;
            out_ovf_q  <= 1'b0;
            in_unf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            rx_ready_q <= rx_ready_d;
            out_ovf_q  <= out_ovf_d;
            in_unf_q   <= in_unf_d;
        end
    end

`ifdef IO_RX_INT_EN
    logic int_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_q <= 1'b0;
        end else begin
            int_q <= capture;
        end
    end

    assign cpu_int = int_q;
`else
    // Polling build: the capture strobe has no consumer.
    logic unused_capture;
    assign unused_capture = capture;
    assign cpu_int        = 1'b0;
`endif

    assign cpu_in_data = hold_q;
    assign rx_ready    = rx_ready_q;
    assign out_ovf     = out_ovf_q;
    assign in_unf      = in_unf_q;
endmodule

// File: doc/io_port_ctrl.md
# io_port_ctrl

Peripheral-side controller at the far end of the processor's 16-bit I/O ports.
- Outbound: buffers every value the processor writes with its output-write strobe, then hands the values to an external consumer over a valid/ready handshake.
- Inbound: accepts one word from an external producer over valid/ready, presents it on the processor's input bus, and raises an optional one-cycle interrupt request.
- Sits beside the processor top level, between the processor's `in`/`out` pins and the board-level I/O.

## Interface
Parameters:
- `OUT_DEPTH`, 4: outbound FIFO entries; power of two, ≥ 2.
- `DATA_W`, 16: port data width; fixed by the ISA.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cpu_out_data` in 16: processor output bus.
- `cpu_out_we` in 1: processor output-write strobe; one cycle per OUT instruction.
- `cpu_in_data` out 16: drives the processor `in` bus.
- `cpu_in_rd` in 1: processor consumed `cpu_in_data` (IN instruction in execute).
- `cpu_int` out 1: interrupt request pulse to the processor.
- `tx_data` out 16, `tx_valid` out 1, `tx_ready` in 1: outbound handshake.
- `rx_data` in 16, `rx_valid` in 1, `rx_ready` out 1: inbound handshake.
- `out_ovf` out 1: sticky flag; an outbound write was dropped.
- `in_unf` out 1: sticky flag; `cpu_in_rd` arrived with no fresh data.

## Operation
Outbound FIFO:
- Push when `cpu_out_we`; pop when `tx_valid & tx_ready`.
- `tx_valid = !empty`. `tx_data` = head entry, combinational from storage.
- When full, a push is accepted only if a pop occurs in the same cycle. Otherwise the push is dropped and `out_ovf` is set.
- A simultaneous push and pop on an empty FIFO is impossible, because `tx_valid` is 0.
- Pointers are log2(`OUT_DEPTH`) bits and wrap modulo depth. A count register of log2(`OUT_DEPTH`)+1 bits distinguishes full from empty.

Inbound FSM, states `RX_EMPTY` and `RX_LOADED`:
- `RX_EMPTY`:
  - `rx_ready = 1`.
  - On `rx_valid`: capture `rx_data` into the hold register, then go to `RX_LOADED`.
  - `cpu_in_rd` in this state sets `in_unf`; the state does not change.
- `RX_LOADED`:
  - `rx_ready = 0`.
  - On `cpu_in_rd`: go to `RX_EMPTY`.
  - `rx_valid` in the same cycle is not captured, because ready was 0.
- `cpu_in_data` always equals the hold register. It keeps the last captured value after the processor consumes it.

Interrupt:
- `cpu_int` is high for exactly the one cycle after each capture edge.

Sticky flags:
- `out_ovf` and `in_unf` clear only on reset.

## Timing
Reset values:
- State: FIFO empty, pointers and count 0, FSM in `RX_EMPTY`.
- Outputs: `tx_valid` 0, `tx_data` 0, `cpu_in_data` 0, `rx_ready` 1, `cpu_int` 0, `out_ovf` 0, `in_unf` 0.

Latencies:
- Outbound: `cpu_out_we` at edge N gives `tx_valid = 1` with that data after edge N, i.e. 1 cycle.
- Inbound: capture at edge N gives `cpu_in_data` updated and `cpu_int = 1` during cycle N+1.
- Back-to-back `rx_valid` sustains at most one word per processor read. `rx_ready` rises the cycle after the edge that samples `cpu_in_rd`.

Reset:
- Reset asserted mid-transfer discards all FIFO contents and the hold word immediately, asynchronously.
- No handshake completes while `rst` is low.

## Configuration
- `IO_RX_INT_EN` defined: the interrupt pulse logic is compiled in, behaving as described under Operation.
- `IO_RX_INT_EN` undefined: `cpu_int` is tied to 0. No interrupt register exists; the processor must poll.
- All other behaviour is identical in both builds.

## Structure
- Package `io_port_pkg` holds:
  - `DATA_W` constant (16).
  - `rx_state_t` enum (`RX_EMPTY`, `RX_LOADED`).
  - Default `OUT_DEPTH`.
- Sub-module `io_out_fifo`: synchronous FIFO with push, pop, head data, full, empty and drop-on-full logic.
- The top level holds the inbound FSM, the hold register, the interrupt generation and the sticky flags.

## Test plan
- Reset, then write 0x1234 then 0xBEEF with `tx_ready` = 1 → `tx_data` shows 0x1234 then 0xBEEF on consecutive cycles; `tx_valid` falls after the second.
- `tx_ready` = 0, five writes 0x0001..0x0005 with `OUT_DEPTH` = 4 → 0x0005 dropped, `out_ovf` = 1; drain yields 0x0001..0x0004.
- FIFO full with a write and a pop in the same cycle → write accepted, count stays 4, `out_ovf` stays 0.
- `rx_valid` with 0x00A5 → `rx_ready` falls, `cpu_in_data` = 0x00A5, `cpu_int` pulses 1 cycle (IO_RX_INT_EN build); `cpu_in_rd` → `rx_ready` = 1, data still 0x00A5.
- `cpu_in_rd` while `RX_EMPTY` → `in_unf` = 1, no state change.
- `rst` low with 3 words queued and `RX_LOADED` → all outputs return to reset values in the same cycle.
